// File: rtl/autotype_sequencer.sv
// Replays a parameterised script of key-mask/reset presses, each press followed by an equal gap.
// Optional feature macro AUTOTYPE_MANUAL_MERGE_EN ORs a key_in bus into the registered keys.
`timescale 1ns/1ps
module autotype_sequencer #(
    parameter int KEYS        = 3,
    parameter int STEPS       = 8,
    parameter int STEP_CYCLES = 25000000,
    parameter logic [STEPS*(KEYS+1)-1:0] SCRIPT = '0,
    parameter int LOOP        = 0,
    parameter int AUTOSTART   = 1
) (
    input  logic            clk,
    input  logic            reset,
    // start and abort are single-cycle requests sampled on every rising edge; there is
    // no ready: start is simply dropped while busy, and abort always wins over start.
    input  logic            start,
    input  logic            abort,
`ifdef AUTOTYPE_MANUAL_MERGE_EN
    input  logic [KEYS-1:0] key_in,
`endif
    output logic [KEYS-1:0] keys,
    output logic            n_reset_out,
    output logic            busy,
    output logic            done,
    output logic [1:0]      state_dbg
);

    localparam int CW = $clog2(STEP_CYCLES + 1);
    localparam int SW = $clog2(STEPS + 1);
    localparam int IW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, GAP = 2'd2, HALT = 2'd3} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [SW-1:0]   step, step_d;
    logic            auto_arm;
    logic            go, done_d, nrst_d, busy_d;
    logic [KEYS-1:0] keys_d;
    logic [KEYS:0]   entry;
    logic            phase_end, last_step;

    // Script unpacked into a power-of-two table so any step index selects a defined entry.
    logic [KEYS:0] entries [2**IW];
    for (genvar i = 0; i < 2**IW; i++) begin : g_entry
        if (i < STEPS) begin : g_used
            assign entries[i] = SCRIPT[i*(KEYS+1) +: KEYS+1];
        end else begin : g_pad
            assign entries[i] = '0;
        end
    end

    assign phase_end = (cnt == CW'(STEP_CYCLES - 1));
    assign last_step = (step == SW'(STEPS - 1));
    assign state_dbg = state;

    always_comb begin
        state_d = state;
        cnt_d   = cnt + CW'(1);
        step_d  = step;
        done_d  = 1'b0;
        go      = start || auto_arm;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    cnt_d = '0;
                    if (go) begin
                        state_d = PRESS;
                        step_d  = '0;
                    end
                end
                PRESS: begin
                    if (phase_end) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        cnt_d = '0;
                        if (last_step) begin
                            done_d  = 1'b1;
                            step_d  = '0;
                            state_d = (LOOP != 0) ? PRESS : HALT;
                        end else begin
                            step_d  = step + SW'(1);
                            state_d = PRESS;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            endcase
        end
        // Outputs are computed from the next state so the registered values line up with it.
        entry  = entries[step_d[IW-1:0]];
        keys_d = (state_d == PRESS) ? entry[KEYS-1:0] : '0;
        nrst_d = (state_d == PRESS) ? ~entry[KEYS] : 1'b1;
`ifdef AUTOTYPE_MANUAL_MERGE_EN
        keys_d = keys_d | key_in;
`endif
        busy_d = (state_d == PRESS) || (state_d == GAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            step        <= '0;
            auto_arm    <= (AUTOSTART != 0);
            keys        <= '0;
            n_reset_out <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            step        <= step_d;
            auto_arm    <= 1'b0;
            keys        <= keys_d;
            n_reset_out <= nrst_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_autotype_sequencer.sv
// Cycle-by-cycle scoreboard for five autotype_sequencer configurations sharing one clock.
`timescale 1ns/1ps
module tb_autotype_sequencer;

    localparam logic [15:0] SCRIPT = 16'h4018; // {100, 000, 001, reset}
    localparam logic [7:0]  IDLE_V = 8'b000_1_0_0_00;
    localparam int          NCYC   = 80;

    logic clk = 1'b0;
    logic reset, reset_e;
    logic start_a, start_b, abort_b, start_d;
    logic [2:0] key_in_d;

    logic [2:0] keys_o [5];
    logic       nrst_o [5];
    logic       busy_o [5];
    logic       done_o [5];
    logic [1:0] st_o   [5];

    logic [39:0] exp_q[$];
    int          cyc_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    string       names [5] = '{"autostart", "abort", "loop", "manual", "reset_pulse"};

    always #5 clk = ~clk;

    autotype_sequencer #(.KEYS(3), .STEPS(4), .STEP_CYCLES(4), .SCRIPT(SCRIPT), .LOOP(0), .AUTOSTART(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(1'b0),
`ifdef AUTOTYPE_MANUAL_MERGE_EN
        .key_in(3'b000),
`endif
        .keys(keys_o[0]), .n_reset_out(nrst_o[0]), .busy(busy_o[0]), .done(done_o[0]), .state_dbg(st_o[0]));

    autotype_sequencer #(.KEYS(3), .STEPS(4), .STEP_CYCLES(4), .SCRIPT(SCRIPT), .LOOP(0), .AUTOSTART(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
`ifdef AUTOTYPE_MANUAL_MERGE_EN
        .key_in(3'b000),
`endif
        .keys(keys_o[1]), .n_reset_out(nrst_o[1]), .busy(busy_o[1]), .done(done_o[1]), .state_dbg(st_o[1]));

    autotype_sequencer #(.KEYS(3), .STEPS(4), .STEP_CYCLES(4), .SCRIPT(SCRIPT), .LOOP(1), .AUTOSTART(1)) dut_c (
        .clk(clk), .reset(reset), .start(1'b0), .abort(1'b0),
`ifdef AUTOTYPE_MANUAL_MERGE_EN
        .key_in(3'b000),
`endif
        .keys(keys_o[2]), .n_reset_out(nrst_o[2]), .busy(busy_o[2]), .done(done_o[2]), .state_dbg(st_o[2]));

    autotype_sequencer #(.KEYS(3), .STEPS(4), .STEP_CYCLES(4), .SCRIPT(SCRIPT), .LOOP(0), .AUTOSTART(0)) dut_d (
        .clk(clk), .reset(reset), .start(start_d), .abort(1'b0),
`ifdef AUTOTYPE_MANUAL_MERGE_EN
        .key_in(key_in_d),
`endif
        .keys(keys_o[3]), .n_reset_out(nrst_o[3]), .busy(busy_o[3]), .done(done_o[3]), .state_dbg(st_o[3]));

    autotype_sequencer #(.KEYS(3), .STEPS(4), .STEP_CYCLES(4), .SCRIPT(SCRIPT), .LOOP(0), .AUTOSTART(1)) dut_e (
        .clk(clk), .reset(reset_e), .start(1'b0), .abort(1'b0),
`ifdef AUTOTYPE_MANUAL_MERGE_EN
        .key_in(3'b000),
`endif
        .keys(keys_o[4]), .n_reset_out(nrst_o[4]), .busy(busy_o[4]), .done(done_o[4]), .state_dbg(st_o[4]));

    // Expected {keys, n_reset_out, busy, done, state} in cycle t of a run that entered PRESS in cycle 1.
    // Hand timeline: 8 cycles per step (4 press + 4 gap); step masks reset/001/000/100; done in cycle 33.
    function automatic logic [7:0] exp_run(int t, bit loop);
        int p;
        logic [2:0] k;
        logic nr;
        if (t < 1) return IDLE_V;
        if (!loop && t > 32) return {3'b000, 1'b1, 1'b0, (t == 33), 2'd3};
        p  = (t - 1) % 32;
        k  = 3'b000;
        nr = 1'b1;
        if ((p % 8) < 4) begin
            case (p / 8)
                0: nr = 1'b0;
                1: k  = 3'b001;
                3: k  = 3'b100;
                default: ;
            endcase
            return {k, nr, 1'b1, (loop && t > 32 && p == 0), 2'd1};
        end
        return {3'b000, 1'b1, 1'b1, 1'b0, 2'd2};
    endfunction

    function automatic logic [39:0] exp_vec(int c);
        logic [7:0] a, b, l, m, r;
        if (c == 0) return {5{IDLE_V}};
        a = (c <= 40) ? exp_run(c, 0) : exp_run(c - 40, 0);
        b = (c <= 10) ? exp_run(c, 0) : IDLE_V;
        l = exp_run(c, 1);
        m = (c <= 5) ? IDLE_V : exp_run(c - 5, 0);
`ifdef AUTOTYPE_MANUAL_MERGE_EN
        if (c >= 3) m[7:5] = m[7:5] | 3'b010;
`endif
        r = (c <= 13) ? exp_run(c, 0) : (c <= 15) ? IDLE_V : exp_run(c - 15, 0);
        return {a, b, l, m, r};
    endfunction

    task automatic drive(int c);
        start_a  = (c == 40);
        abort_b  = (c == 10) || (c == 20);
        start_b  = (c == 20);
        start_d  = (c == 5) || (c == 8);
        reset_e  = (c == 14);
        key_in_d = (c >= 2) ? 3'b010 : 3'b000;
    endtask

    task automatic push(int c);
        exp_q.push_back(exp_vec(c));
        cyc_q.push_back(c);
    endtask

    // Monitor: every falling edge, pop the expected vector and compare each instance.
    initial begin
        logic [39:0] e;
        logic [7:0]  act;
        int          c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                for (int k = 0; k < 5; k++) begin
                    act = {keys_o[k], nrst_o[k], busy_o[k], done_o[k], st_o[k]};
                    n_vec++;
                    if (act !== e[8*(4-k) +: 8]) begin
                        n_err++;
                        $display("FAIL cycle %0d %s {keys,nrst,busy,done,state}: got %b expected %b",
                                 c, names[k], act, e[8*(4-k) +: 8]);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(0);
        reset_e = 1'b1;
        repeat (2) @(posedge clk);
        #1 push(0);
        @(negedge clk);
        #1;
        reset   = 1'b0;
        reset_e = 1'b0;
        for (int c = 1; c <= NCYC; c++) begin
            @(posedge clk);
            #1;
            drive(c);
            push(c);
        end
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
